// File: rtl/convertir_bornes_bcd_seq.sv
// Sequential die-range converter: turns the face count max_de + 1 - min_de into N_DIG BCD
// digits by double dabble, with blanking, saturation and range-error flags.
module convertir_bornes_bcd_seq #(
  parameter int unsigned W_IN  = 7,
  parameter int unsigned N_DIG = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W_IN-1:0]      min_de,
  input  logic [W_IN-1:0]      max_de,
  output logic [4*N_DIG-1:0]   bcd,
  output logic [N_DIG-1:0]     en,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 err
);

  // Decimal digits needed to hold 2^w, the largest possible face count.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned p;
    int unsigned     n;
    p = 64'd1 << w;
    n = 0;
    for (int i = 0; i < 21; i++) begin
      if (p != 0) begin
        p = p / 10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int unsigned VW = W_IN + 1;
  localparam int unsigned HD = dec_digits(W_IN);
  localparam int unsigned ND = (HD > N_DIG) ? HD : N_DIG;
  localparam int unsigned SW = 4 * ND;
  localparam int unsigned CW = $clog2(VW);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]          state_q;
  logic [VW-1:0]       val_q;
  logic [SW-1:0]       scr_q;
  logic [SW-1:0]       scr_next;
  logic [CW-1:0]       cnt_q;
  logic                err_lat_q;
  logic [4*N_DIG-1:0]  bcd_q;
  logic [N_DIG-1:0]    en_q;
  logic                ovf_q;
  logic                err_q;
  logic                done_q;

  logic                range_err;
  logic [VW-1:0]       v_init;
  logic                hi_nz;
  logic [4*N_DIG-1:0]  res_bcd;
  logic [4*N_DIG-1:0]  sat_bcd;
  logic [N_DIG-1:0]    res_en;

  assign range_err = min_de > max_de;
  assign v_init    = range_err ? '0 : ({1'b0, max_de} + VW'(1) - {1'b0, min_de});

  // One double-dabble step: add 3 to columns >= 5, then shift {scratch, value} left by one.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    carry    = val_q[VW-1];
    scr_next = '0;
    for (int i = 0; i < int'(ND); i++) begin
      nib = scr_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      scr_next[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  // Result formatting from the finished scratch register.
  always_comb begin
    logic nz;
    hi_nz = 1'b0;
    for (int i = int'(N_DIG); i < int'(ND); i++) begin
      hi_nz = hi_nz | (|scr_q[4*i +: 4]);
    end
    res_bcd = scr_q[4*N_DIG-1:0];
    sat_bcd = '0;
    res_en  = '0;
    nz      = 1'b0;
    for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
      nz = nz | (|res_bcd[4*i +: 4]);
      res_en[i] = nz;
      sat_bcd[4*i +: 4] = 4'd9;
    end
    res_en[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      val_q     <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      err_lat_q <= 1'b0;
      bcd_q     <= '0;
      en_q      <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            val_q     <= v_init;
            err_lat_q <= range_err;
            scr_q     <= '0;
            cnt_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_next;
          val_q <= {val_q[VW-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W_IN)) state_q <= FINISH;
        end
        FINISH: begin
          if (err_lat_q) begin
            bcd_q <= '0;
            en_q  <= N_DIG'(1);
            ovf_q <= 1'b0;
            err_q <= 1'b1;
          end else if (hi_nz) begin
            bcd_q <= sat_bcd;
            en_q  <= '1;
            ovf_q <= 1'b1;
            err_q <= 1'b0;
          end else begin
            bcd_q <= res_bcd;
            en_q  <= res_en;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign en   = en_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_convertir_bornes_bcd_seq.sv
// Bench for convertir_bornes_bcd_seq: a 3-digit and a 2-digit instance share stimulus and are
// checked against an arithmetic reference model.
module tb_convertir_bornes_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  min_de = '0;
  logic [6:0]  max_de = '0;

  logic [11:0] bcd_a;
  logic [2:0]  en_a;
  logic        busy_a, done_a, ovf_a, err_a;
  logic [7:0]  bcd_b;
  logic [1:0]  en_b;
  logic        busy_b, done_b, ovf_b, err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  convertir_bornes_bcd_seq #(.W_IN(7), .N_DIG(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .min_de(min_de), .max_de(max_de),
    .bcd(bcd_a), .en(en_a), .busy(busy_a), .done(done_a), .ovf(ovf_a), .err(err_a)
  );

  convertir_bornes_bcd_seq #(.W_IN(7), .N_DIG(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .min_de(min_de), .max_de(max_de),
    .bcd(bcd_b), .en(en_b), .busy(busy_b), .done(done_b), .ovf(ovf_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: face count by plain arithmetic, digits by division.
  task automatic model(input int mn, input int mx, input int nd,
                       output logic [31:0] e_bcd, output logic [31:0] e_en,
                       output logic [31:0] e_ovf, output logic [31:0] e_err);
    int v;
    e_bcd = 0; e_en = 1; e_ovf = 0; e_err = 0;
    if (mn > mx) begin
      e_err = 1;
    end else begin
      v = mx + 1 - mn;
      if (v >= 10 ** nd) begin
        e_ovf = 1;
        e_en  = (1 << nd) - 1;
        for (int i = 0; i < nd; i++) e_bcd = e_bcd | (32'd9 << (4 * i));
      end else begin
        for (int i = 0; i < nd; i++) begin
          e_bcd = e_bcd | (((v / (10 ** i)) % 10) << (4 * i));
          if (i > 0 && v >= 10 ** i) e_en = e_en | (1 << i);
        end
      end
    end
  endtask

  task automatic check_outputs(input int mn, input int mx);
    logic [31:0] eb, ee, eo, er;
    model(mn, mx, 3, eb, ee, eo, er);
    check($sformatf("bcd3 %0d/%0d", mn, mx), 32'(bcd_a), eb);
    check($sformatf("en3 %0d/%0d", mn, mx), 32'(en_a), ee);
    check($sformatf("ovf3 %0d/%0d", mn, mx), 32'(ovf_a), eo);
    check($sformatf("err3 %0d/%0d", mn, mx), 32'(err_a), er);
    model(mn, mx, 2, eb, ee, eo, er);
    check($sformatf("bcd2 %0d/%0d", mn, mx), 32'(bcd_b), eb);
    check($sformatf("en2 %0d/%0d", mn, mx), 32'(en_b), ee);
    check($sformatf("ovf2 %0d/%0d", mn, mx), 32'(ovf_b), eo);
    check($sformatf("err2 %0d/%0d", mn, mx), 32'(err_b), er);
  endtask

  // One start pulse; operands are scrambled after acceptance to prove they were captured.
  task automatic run_conv(input int mn, input int mx);
    int  n;
    bit  seen;
    @(negedge clk);
    min_de = 7'(mn);
    max_de = 7'(mx);
    start  = 1'b1;
    n      = 0;
    seen   = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        start  = 1'b0;
        min_de = 7'($urandom);
        max_de = 7'($urandom);
        check("busy_after_start", 32'(busy_a), 1);
      end
      if (done_a) seen = 1;
    end
    check("latency", n - 1, 9);
    check("done_both", 32'(done_b), 1);
    check("busy_at_done", 32'(busy_a), 0);
    check_outputs(mn, mx);
    @(negedge clk);
    check("done_one_cycle", 32'(done_a), 0);
  endtask

  initial begin
    int ndone;
    int busy_lo;
    int mn, mx;

    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bcd_a), 0);
    check("rst_en", 32'(en_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_err", 32'(err_a), 0);
    reset = 1'b0;

    run_conv(1, 6);
    run_conv(1, 100);
    run_conv(0, 127);
    run_conv(0, 0);
    run_conv(10, 5);
    run_conv(1, 20);
    run_conv(0, 98);
    run_conv(0, 99);
    run_conv(127, 127);
    run_conv(127, 0);

    for (int k = 0; k < 30; k++) begin
      mn = int'($urandom_range(0, 127));
      mx = (k % 5 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(mn, 127));
      run_conv(mn, mx);
    end

    // start held high: back-to-back conversions every 10 cycles
    @(negedge clk);
    min_de = 7'd1;
    max_de = 7'd20;
    start  = 1'b1;
    ndone  = 0;
    busy_lo = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a) begin
        ndone++;
        check("b2b_done_pos", n, ndone * 10);
        check("b2b_bcd", 32'(bcd_a), 32'h020);
        check("b2b_en", 32'(en_a), 32'b011);
      end
      if (n <= 19 && !busy_a) busy_lo++;
      if (n == 20) start = 1'b0;
    end
    check("b2b_count", ndone, 2);
    check("b2b_busy_gap", busy_lo, 1);

    // reset in the middle of a conversion
    run_conv(1, 100);
    @(negedge clk);
    min_de = 7'd1;
    max_de = 7'd100;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_bcd", 32'(bcd_a), 0);
    check("abort_en", 32'(en_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    check("abort_ovf", 32'(ovf_b), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_conv(1, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/convertir_bornes_bcd_seq.md
# convertir_bornes_bcd_seq

Sequential, parametrised successor to the combinational die-range display converter. Captures the die bounds `min_de`/`max_de`, computes the face count `max_de + 1 - min_de` and converts it to `N_DIG` BCD digits by iterative shift-add-3 (double dabble). Adds a start/busy/done handshake, per-digit leading-zero blanking, overflow saturation and invalid-range detection. Sits between the die-configuration logic and the 7-segment digit drivers.

## Interface
- `W_IN`, 7, width of `min_de`/`max_de`; internal value width is `W_IN+1`.
- `N_DIG`, 3, number of BCD output digits (≥1).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: conversion request, sampled only in IDLE.
- `min_de` input `W_IN`: lower die bound, unsigned.
- `max_de` input `W_IN`: upper die bound, unsigned.
- `bcd` output `4*N_DIG`: digit i in bits `[4i+3:4i]`, digit 0 = units.
- `en` output `N_DIG`: digit i display enable (leading-zero blanking).
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse, new result valid.
- `ovf` output 1: face count ≥ 10^N_DIG.
- `err` output 1: `min_de > max_de`.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: `start`=1 → register operands; value V = `max_de + 1 - min_de` in `W_IN+1` bits, no wrap; if `min_de > max_de`, V = 0 and latched err flag = 1. Clear shift register and iteration counter; go SHIFT.
- SHIFT: per cycle, every 4-bit BCD column ≥5 gets +3, then shift {BCD, V} left by 1. Exactly `W_IN+1` iterations; after last → FINISH.
- FINISH: load output registers, pulse `done`, return to IDLE.
- BCD scratch width is `4*N_DIG` plus enough headroom to hold all digits of 2^W_IN; digits above `N_DIG` are used only for overflow detection.
- Overflow: if V ≥ 10^N_DIG, `ovf`=1, every digit of `bcd` = 9, all `en` = 1.
- Blanking: `en[0]` = 1 always after a conversion; `en[i]` (i≥1) = 1 iff some digit j ≥ i is nonzero.
- `err`=1 → `bcd` = 0, `en` = only bit 0, `ovf` = 0.
- `start` ignored while `busy`; never queued.
- Outputs `bcd`, `en`, `ovf`, `err` hold their values until the next FINISH.

## Timing
- Reset (asynchronous, immediate): state IDLE, `bcd`=0, `en`=0, `busy`=0, `done`=0, `ovf`=0, `err`=0, counter=0.
- `start` sampled high at edge 0 in IDLE → `busy`=1 from edge 0.
- SHIFT occupies edges 1..`W_IN+1`; FINISH at edge `W_IN+2` updates outputs, `done`=1 and `busy`=0 for the cycle after edge `W_IN+2`.
- Latency start→done: `W_IN+2` cycles (9 with defaults); throughput one conversion per `W_IN+3` cycles.
- `start` high in the same cycle `done` is high is accepted (FSM already in IDLE).
- Reset mid-conversion aborts; no `done`, outputs return to reset values.
- Operand changes after edge 0 have no effect on the running conversion.

## Test plan
- Defaults, `min_de`=1, `max_de`=6, start pulse → `done` 9 cycles later, `bcd`=0x006, `en`=001, `ovf`=0, `err`=0.
- `min_de`=1, `max_de`=100 → `bcd`=0x100, `en`=111; `min_de`=0, `max_de`=127 → `bcd`=0x128, `en`=111.
- `min_de`=`max_de`=0 → V=1, `bcd`=0x001, `en`=001; `min_de`=10, `max_de`=5 → `err`=1, `bcd`=0x000, `en`=001.
- `N_DIG`=2, `min_de`=1, `max_de`=100 → `ovf`=1, `bcd`=0x99, `en`=11; `max_de`=20 → `ovf`=0, `bcd`=0x20, `en`=11.
- `start` held high for 20 cycles with operands 1/20 → back-to-back conversions every 10 cycles, each giving `bcd`=0x020, `en`=011; `busy` drops for exactly one cycle between conversions.
- Assert `reset` at cycle 4 of a 1/100 conversion → all outputs 0 immediately, no `done`; next start yields correct 0x100.
